// File: rtl/sample_src_pkg.sv
// sample_src_pkg: shared widths, sizes and the phase-to-sample mapping for the
// tone sample source. The build macro SAMPLE_SRC_OVERRUN_EN (see
// tone_sample_source) does not affect anything in this package.
package sample_src_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int PHASE_W    = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int INC_UNIT   = 64;
  localparam int SEL_W      = 4;

  // Pointer width addresses FIFO_DEPTH slots; the count needs one more bit
  // so that a completely full buffer (FIFO_DEPTH) is representable.
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [PHASE_W-1:0]  phase_t;

  // Unsigned triangle: the lower half of the phase circle ramps up, the upper
  // half ramps down, peaking at 0xFFFE just after the midpoint.
  function automatic sample_t tri_sample(input phase_t p);
    return p[PHASE_W-1] ? {~p[PHASE_W-2:0], 1'b0} : {p[PHASE_W-2:0], 1'b0};
  endfunction

  // Phase step for a tone select: (sel + 1) * INC_UNIT, so 64..1024.
  function automatic phase_t phase_inc(input logic [SEL_W-1:0] sel);
    return (PHASE_W'(sel) + PHASE_W'(1)) * PHASE_W'(INC_UNIT);
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: small synchronous in-order sample buffer. Count, full and empty
// are registers updated on every edge. A push while full is accepted only
// when a pop happens on the same edge; a pop while empty is ignored.
module sample_fifo
  import sample_src_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  sample_t          din,
  output sample_t          dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  sample_t          mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_next;
  logic             full_q;
  logic             empty_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & ~empty_q;
  assign do_push = push & (~full_q | do_pop);

  // Occupancy after this edge; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next = count_q;
    if (do_push && !do_pop) begin
      count_next = count_q + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_next = count_q - CNT_W'(1);
    end
  end

  // Storage write; contents need no reset because empty gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count_q <= count_next;
      full_q  <= (count_next == CNT_W'(FIFO_DEPTH));
      empty_q <= (count_next == '0);
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: rtl/tone_sample_source.sv
// tone_sample_source: generates triangle-wave samples at the clkFreq strobe
// rate, buffers them in sample_fifo and hands them to the filter controller.
// Build macro SAMPLE_SRC_OVERRUN_EN adds a sticky 'overrun' output that flags
// any sample dropped because the buffer was full.
//
// Handshake: ld_newsample is the consumer's ready/request level. When it is
// high, the buffer is non-empty and no pulse is currently shown, the head is
// moved into newSample and newsampleloaded (the valid strobe) is high for
// exactly one cycle. The consumer drops ld_newsample within one cycle of the
// strobe; a request still high after that is treated as a new request, so
// samples leave at most once every two cycles.
module tone_sample_source
  import sample_src_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clkFreq,
  input  logic [3:0]  selectTone,
  input  logic        ld_newsample,
  output logic [15:0] newSample,
  output logic        newsampleloaded,
  output logic [2:0]  fifoCount
`ifdef SAMPLE_SRC_OVERRUN_EN
  ,
  output logic        overrun
`endif
);

  logic             clk_freq_q;
  logic             tick;
  phase_t           phase_q;
  logic             pop_go;
  logic             push_go;
  sample_t          fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  sample_t          new_sample_q;
  logic             loaded_q;

  // Strobe history; loaded during reset too so a strobe already high when
  // reset releases is not mistaken for a fresh rising edge.
  always_ff @(posedge clk) begin
    clk_freq_q <= clkFreq;
  end

  assign tick = clkFreq & ~clk_freq_q;

  // A pop needs a request, data, and no pulse already on display.
  assign pop_go  = ld_newsample & ~fifo_empty & ~loaded_q;
  // Full buffer takes the new sample only if the head leaves on the same edge.
  assign push_go = tick & (~fifo_full | pop_go);

  // Phase accumulator: advances on every tick, wrapping modulo 2^16, whether
  // or not the sample was stored.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= '0;
    end else if (tick) begin
      phase_q <= phase_q + phase_inc(selectTone);
    end
  end

  // Output register and one-cycle valid strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      new_sample_q <= '0;
      loaded_q     <= 1'b0;
    end else if (pop_go) begin
      new_sample_q <= fifo_head;
      loaded_q     <= 1'b1;
    end else begin
      loaded_q     <= 1'b0;
    end
  end

  sample_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_go),
    .pop   (pop_go),
    .din   (tri_sample(phase_q)),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef SAMPLE_SRC_OVERRUN_EN
  logic overrun_q;

  // Sticky drop flag: set by a tick that finds the buffer full with no pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else if (tick && fifo_full && !pop_go) begin
      overrun_q <= 1'b1;
    end
  end

  assign overrun = overrun_q;
`endif

  assign newSample       = new_sample_q;
  assign newsampleloaded = loaded_q;
  assign fifoCount       = fifo_count;

endmodule

// File: tb/tb_tone_sample_source.sv
// tb_tone_sample_source: randomized and directed stimulus against a queue-based
// reference model of the tone sample source, with a scoreboard monitor.
module tb_tone_sample_source;

  logic        clk;
  logic        reset;
  logic        clkFreq;
  logic [3:0]  selectTone;
  logic        ld_newsample;
  logic [15:0] newSample;
  logic        newsampleloaded;
  logic [2:0]  fifoCount;
`ifdef SAMPLE_SRC_OVERRUN_EN
  logic        overrun;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  // scoreboard / model state
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  logic [15:0] m_q[$];
  int          m_phase;
  logic        m_prev;
  logic        m_pulse;
  logic        m_overrun;
  logic        prev_loaded;

  tone_sample_source dut (
    .clk             (clk),
    .reset           (reset),
    .clkFreq         (clkFreq),
    .selectTone      (selectTone),
    .ld_newsample    (ld_newsample),
    .newSample       (newSample),
    .newsampleloaded (newsampleloaded),
    .fifoCount       (fifoCount)
`ifdef SAMPLE_SRC_OVERRUN_EN
    ,
    .overrun         (overrun)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // ---------------- helpers ----------------
  function automatic logic [15:0] ref_sample(input int p);
    if (p >= 32768) return 16'((65535 - p) * 2);
    return 16'(p * 2);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model (one step per clock edge) ----------------
  always @(posedge clk) begin
    if (reset) begin
      m_phase   = 0;
      m_q.delete();
      m_pulse   = 1'b0;
      m_prev    = clkFreq;
      m_overrun = 1'b0;
    end else begin
      bit t;
      t      = clkFreq && !m_prev;
      m_prev = clkFreq;
      if (ld_newsample && m_q.size() > 0 && !m_pulse) begin
        exp_q.push_back(m_q.pop_front());
        m_pulse = 1'b1;
      end else begin
        m_pulse = 1'b0;
      end
      if (t) begin
        if (m_q.size() < 4) m_q.push_back(ref_sample(m_phase));
        else m_overrun = 1'b1;
        m_phase = (m_phase + (int'(selectTone) + 1) * 64) % 65536;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial prev_loaded = 1'b0;
  always @(negedge clk) begin
    check("fifo_count", 32'(fifoCount), 32'(m_q.size()));
    check("loaded_timing", 32'(newsampleloaded), 32'(m_pulse));
    check("pulse_width", 32'(newsampleloaded && prev_loaded), 32'(0));
`ifdef SAMPLE_SRC_OVERRUN_EN
    check("overrun", 32'(overrun), 32'(m_overrun));
`endif
    if (newsampleloaded) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", 32'(1), 32'(0));
      end else begin
        check("sample", 32'(newSample), 32'(exp_q.pop_front()));
      end
      got_q.push_back(newSample);
    end else if (m_pulse && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
    end
    prev_loaded = newsampleloaded;
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
  endtask

  task automatic tick_once();
    @(negedge clk);
    clkFreq = 1'b1;
    @(negedge clk);
    clkFreq = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int inc;
    reset        = 1'b1;
    clkFreq      = 1'b0;
    selectTone   = 4'd0;
    ld_newsample = 1'b0;
    cycles(3);
    check("reset_count", 32'(fifoCount), 32'(0));
    check("reset_sample", 32'(newSample), 32'(0));
    check("reset_loaded", 32'(newsampleloaded), 32'(0));
    reset = 1'b0;

    // three ticks at the slowest tone with the request held
    got_q.delete();
    selectTone   = 4'd0;
    ld_newsample = 1'b1;
    repeat (3) tick_once();
    cycles(4);
    ld_newsample = 1'b0;
    check("slow_pop_count", 32'(got_q.size()), 32'(3));
    if (got_q.size() == 3) begin
      check("slow_pop0", 32'(got_q[0]), 32'h0000);
      check("slow_pop1", 32'(got_q[1]), 32'h0080);
      check("slow_pop2", 32'(got_q[2]), 32'h0100);
    end

    // fastest tone across a full phase cycle, including peak and wrap
    do_reset();
    got_q.delete();
    selectTone   = 4'd15;
    ld_newsample = 1'b1;
    repeat (65) tick_once();
    cycles(4);
    ld_newsample = 1'b0;
    check("fast_pop_count", 32'(got_q.size()), 32'(65));
    if (got_q.size() == 65) begin
      check("fast_step", 32'(got_q[1]), 32'h0800);
      check("fast_peak", 32'(got_q[32]), 32'hFFFE);
      check("fast_last", 32'(got_q[63]), 32'h07FE);
      check("fast_wrap", 32'(got_q[64]), 32'h0000);
    end

    // overflow: six ticks without requests, samples 5 and 6 lost
    do_reset();
    got_q.delete();
    selectTone = 4'($urandom_range(0, 15));
    inc = (int'(selectTone) + 1) * 64;
    repeat (6) tick_once();
    cycles(2);
    check("ovf_count", 32'(fifoCount), 32'(4));
`ifdef SAMPLE_SRC_OVERRUN_EN
    check("ovf_flag", 32'(overrun), 32'(1));
`endif
    ld_newsample = 1'b1;
    cycles(12);
    ld_newsample = 1'b0;
    check("ovf_pop_count", 32'(got_q.size()), 32'(4));
    if (got_q.size() == 4)
      for (int k = 0; k < 4; k++) check("ovf_pop", 32'(got_q[k]), 32'(ref_sample(k * inc)));

    // full buffer, tick and pop on the same edge
    do_reset();
    got_q.delete();
    selectTone = 4'd2;
    inc = 3 * 64;
    repeat (4) tick_once();
    cycles(2);
    @(negedge clk);
    ld_newsample = 1'b1;
    clkFreq      = 1'b1;
    @(negedge clk);
    check("full_pp_count", 32'(fifoCount), 32'(4));
    check("full_pp_loaded", 32'(newsampleloaded), 32'(1));
`ifdef SAMPLE_SRC_OVERRUN_EN
    check("full_pp_overrun", 32'(overrun), 32'(0));
`endif
    ld_newsample = 1'b0;
    clkFreq      = 1'b0;
    cycles(2);
    ld_newsample = 1'b1;
    cycles(12);
    ld_newsample = 1'b0;
    check("full_pp_pops", 32'(got_q.size()), 32'(5));
    if (got_q.size() == 5)
      for (int k = 0; k < 5; k++) check("full_pp_val", 32'(got_q[k]), 32'(ref_sample(k * inc)));

    // request while empty, then a tick: pulse one edge after the push
    do_reset();
    got_q.delete();
    ld_newsample = 1'b1;
    cycles(5);
    check("empty_no_pop", 32'(got_q.size()), 32'(0));
    @(negedge clk);
    clkFreq = 1'b1;
    @(negedge clk);
    check("empty_push_count", 32'(fifoCount), 32'(1));
    check("empty_no_bypass", 32'(newsampleloaded), 32'(0));
    clkFreq = 1'b0;
    @(negedge clk);
    check("empty_then_pop", 32'(newsampleloaded), 32'(1));
    check("empty_pop_val", 32'(newSample), 32'h0000);
    ld_newsample = 1'b0;

    // reset with three buffered samples and the strobe held high
    do_reset();
    selectTone = 4'd5;
    repeat (3) tick_once();
    cycles(1);
    check("pre_reset_count", 32'(fifoCount), 32'(3));
    @(negedge clk);
    reset   = 1'b1;
    clkFreq = 1'b1;
    cycles(2);
    reset = 1'b0;
    cycles(4);
    check("post_reset_count", 32'(fifoCount), 32'(0));
    check("post_reset_sample", 32'(newSample), 32'(0));
    @(negedge clk);
    clkFreq = 1'b0;
    tick_once();
    check("retick_count", 32'(fifoCount), 32'(1));

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      clkFreq = ($urandom_range(0, 2) == 0) ? ~clkFreq : clkFreq;
      if ($urandom_range(0, 3) == 0) ld_newsample = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 40) == 0) selectTone = 4'($urandom_range(0, 15));
      reset = ($urandom_range(0, 250) == 0);
    end
    @(negedge clk);
    reset        = 1'b0;
    clkFreq      = 1'b0;
    ld_newsample = 1'b1;
    cycles(20);
    ld_newsample = 1'b0;
    cycles(2);
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
